uart_send: RTL and testbench
============================

Name: uart_send

Overview:
- 8N1 UART transmitter with a small input byte FIFO; sits directly downstream of the UART receiver in the loopback path.
- Accepts single-cycle byte strobes (same format as the receiver's recv_data/finish_flag pair).
- Buffers the bytes and serialises them on uart_tx at the configured baud rate, so bursts from the receiver are never lost while a frame is in flight.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- UART_BPS, 9600, baud rate.
  - BIT_CNT_MAX = CLK_FREQ / UART_BPS, integer division (5208 at defaults).
- FIFO_DEPTH, 8, byte FIFO depth; power of 2, minimum 2.

Ports:
- sys_clk  input  1  system clock, all logic on rising edge.
- sys_rst  input  1  reset, synchronous, active-low.
- send_data  input  8  byte to transmit; sampled only when send_en=1.
- send_en  input  1  single-cycle write strobe.
- uart_tx  output  1  serial line, idle high.
- tx_busy  output  1  1 while a frame is in progress or the FIFO is non-empty.
- fifo_full  output  1  1 when the FIFO count equals FIFO_DEPTH.
- overflow  output  1  one-cycle pulse when a byte is dropped.

Behaviour:
- Reset is synchronous and active-low: when sys_rst=0 at a rising edge, the block resets.
  - Reset values: uart_tx=1, tx_busy=0, fifo_full=0, overflow=0.
  - FIFO pointers and count clear to 0; FSM goes to IDLE; baud counter and bit index clear to 0.
  - A frame in progress is aborted; the line is high from the edge after reset is sampled.
- FIFO:
  - Write is accepted iff send_en=1 and the registered count < FIFO_DEPTH before the edge.
  - send_en=1 while full: byte dropped, overflow=1 for exactly the next cycle, FIFO unchanged.
  - A pop in the same cycle does NOT free a slot for a simultaneous write on a full FIFO.
  - Simultaneous write and pop on a non-full, non-empty FIFO leaves the count unchanged.
  - Pointers are log2(FIFO_DEPTH) bits wide and wrap naturally; count is log2(FIFO_DEPTH)+1 bits.
  - fifo_full and tx_busy are registered and consistent with the post-edge state.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE:
    - If the FIFO is non-empty: pop the head into the shift register, go to START, drive uart_tx=0.
    - Otherwise stay in IDLE with uart_tx=1.
  - START: hold 0 for BIT_CNT_MAX cycles, then go to DATA with bit index 0.
  - DATA:
    - Drive shift register bit[index], LSB first; each bit lasts BIT_CNT_MAX cycles.
    - After index 7 completes, go to STOP.
  - STOP: hold 1 for BIT_CNT_MAX cycles. At the end of the stop bit:
    - If the FIFO is non-empty: pop, go straight to START with no idle gap.
    - Otherwise go to IDLE.
- Baud counter:
  - Counts 0 .. BIT_CNT_MAX-1; reset to 0 on every bit boundary and in IDLE.
  - The bit-end condition is counter == BIT_CNT_MAX-1.
- Latency: a byte written at edge N into an empty FIFO with the FSM in IDLE makes uart_tx fall after edge N+1.
- Frame length: exactly 10*BIT_CNT_MAX cycles, from the falling start edge to the end of the stop bit.
- send_data is not required to stay stable after its strobe cycle.

Test Plan:
Bench parameters: CLK_FREQ=1_000_000, UART_BPS=100_000 (BIT_CNT_MAX=10), FIFO_DEPTH=4.
- Single byte 0xA5 written while idle:
  - uart_tx falls 1 cycle after the write edge.
  - Line then carries 0,1,0,1,0,0,1,0,1,1, each bit 10 cycles.
  - tx_busy stays high for 100 cycles, then returns to 0.
- Burst of 0x01,0x02,0x03 on consecutive cycles:
  - Three contiguous 100-cycle frames with no idle high between stop and start.
  - Decoded bytes are 0x01,0x02,0x03 in order.
- Overflow: write 6 bytes on consecutive cycles from idle.
  - The first pops immediately; bytes 2-5 fill the FIFO (fifo_full=1).
  - The 6th is dropped with a one-cycle overflow pulse.
  - Exactly 5 frames are transmitted.
- Full with simultaneous pop:
  - Setup: FIFO full, write on the cycle the STOP bit ends.
  - Required: the write is dropped with an overflow pulse; the count becomes FIFO_DEPTH-1.
- Reset mid-frame: assert sys_rst=0 during DATA bit 3 of 0x00.
  - uart_tx=1 and tx_busy=0 after that edge; FIFO empty.
  - After release, no residual frame is sent.
- Pointer wrap: write and transmit 10 distinct bytes in groups of 3.
  - All 10 bytes are received in order, with no duplication across the pointer wrap.

Source files
------------

// File: rtl/uart_send.sv
// 8N1 UART transmitter with a small byte FIFO in front of it.
// Bytes arrive as single-cycle strobes and are serialised LSB first at UART_BPS.
module uart_send #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int UART_BPS   = 9600,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] send_data,
  input  logic       send_en,
  output logic       uart_tx,
  output logic       tx_busy,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int BIT_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int CNT_W       = $clog2(BIT_CNT_MAX + 1);
  localparam int PTR_W       = $clog2(FIFO_DEPTH);
  localparam int FCNT_W      = PTR_W + 1;

  localparam logic [CNT_W-1:0]  BIT_END = CNT_W'(BIT_CNT_MAX - 1);
  localparam logic [FCNT_W-1:0] DEPTH_C = FCNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [FCNT_W-1:0] fifo_cnt;
  logic [FCNT_W-1:0] fifo_cnt_next;

  state_t            state;
  logic [CNT_W-1:0]  baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift_reg;

  logic              wr_ok;
  logic              fifo_empty;
  logic              bit_end;
  logic              pop;
  logic              going_idle;

  // Pops only happen from IDLE or at the very end of a stop bit, and both
  // decisions look at the pre-edge count, so a full FIFO never gains a slot
  // for a write landing on the same edge as a pop.
  always_comb begin
    wr_ok      = send_en && (fifo_cnt < DEPTH_C);
    fifo_empty = (fifo_cnt == '0);
    bit_end    = (baud_cnt == BIT_END);
    pop        = 1'b0;
    going_idle = 1'b0;
    case (state)
      IDLE: begin
        pop        = !fifo_empty;
        going_idle = fifo_empty;
      end
      STOP: begin
        if (bit_end) begin
          pop        = !fifo_empty;
          going_idle = fifo_empty;
        end
      end
      default: ;
    endcase
    fifo_cnt_next = fifo_cnt + FCNT_W'(wr_ok) - FCNT_W'(pop);
  end

  always_ff @(posedge sys_clk) begin
    if (wr_ok) begin
      fifo_mem[wr_ptr] <= send_data;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      fifo_full <= 1'b0;
      overflow  <= 1'b0;
      tx_busy   <= 1'b0;
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      uart_tx   <= 1'b1;
    end else begin
      overflow  <= send_en && !wr_ok;
      fifo_cnt  <= fifo_cnt_next;
      fifo_full <= (fifo_cnt_next == DEPTH_C);
      tx_busy   <= !going_idle || (fifo_cnt_next != '0);

      if (wr_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end

      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_idx  <= '0;
          if (pop) begin
            shift_reg <= fifo_mem[rd_ptr];
            state     <= START;
            uart_tx   <= 1'b0;
          end else begin
            uart_tx <= 1'b1;
          end
        end

        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            uart_tx  <= shift_reg[0];
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state   <= STOP;
              uart_tx <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              uart_tx <= shift_reg[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            // Back-to-back frames: the next start bit follows the stop bit directly.
            if (pop) begin
              shift_reg <= fifo_mem[rd_ptr];
              state     <= START;
              uart_tx   <= 1'b0;
            end else begin
              state   <= IDLE;
              uart_tx <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        default: begin
          state   <= IDLE;
          uart_tx <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_send.sv
// Directed bench for uart_send: per-cycle line checks from a vector table,
// plus burst, overflow, full-with-pop, mid-frame reset and pointer-wrap sequences.
module tb_uart_send;

  localparam int CLK_FREQ   = 1_000_000;
  localparam int UART_BPS   = 100_000;
  localparam int FIFO_DEPTH = 4;

  logic       sys_clk   = 1'b0;
  logic       sys_rst   = 1'b0;
  logic [7:0] send_data = 8'h00;
  logic       send_en   = 1'b0;
  logic       uart_tx;
  logic       tx_busy;
  logic       fifo_full;
  logic       overflow;

  uart_send #(
    .CLK_FREQ  (CLK_FREQ),
    .UART_BPS  (UART_BPS),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .send_data(send_data),
    .send_en  (send_en),
    .uart_tx  (uart_tx),
    .tx_busy  (tx_busy),
    .fifo_full(fifo_full),
    .overflow (overflow)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;
  } vec_t;

  int total = 0;
  int bad   = 0;

  int         cyc = 0;
  logic [7:0] rx_q[$];
  int         start_q[$];
  int         frame_err = 0;
  logic       mon_active = 1'b0;
  int         mon_k = 0;
  int         mon_start = 0;
  logic [7:0] mon_shift = 8'h00;
  logic       mon_rst;

  // Line decoder: samples mid-bit, records each byte and the cycle its start bit began.
  initial begin : monitor
    forever begin
      @(posedge sys_clk);
      mon_rst = sys_rst;
      #1;
      cyc++;
      if (!mon_rst) begin
        mon_active = 1'b0;
      end else if (!mon_active) begin
        if (uart_tx == 1'b0) begin
          mon_active = 1'b1;
          mon_k      = 0;
          mon_start  = cyc;
        end
      end else begin
        mon_k++;
        if (mon_k == 5 && uart_tx !== 1'b0) frame_err++;
        if (mon_k % 10 == 5 && mon_k >= 15 && mon_k <= 85) mon_shift[mon_k/10 - 1] = uart_tx;
        if (mon_k == 95 && uart_tx !== 1'b1) frame_err++;
        if (mon_k == 99) begin
          rx_q.push_back(mon_shift);
          start_q.push_back(mon_start);
          mon_active = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, wanted %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    send_data = b;
    send_en   = 1'b1;
    tick();
    send_en   = 1'b0;
    send_data = 8'($urandom);
  endtask

  task automatic waitFrames(input int n, input int limit, input string name);
    int i = 0;
    while (rx_q.size() < n && i < limit) begin
      tick();
      i++;
    end
    checkOutput(name, rx_q.size(), n);
  endtask

  task automatic waitIdle(input int limit, input string name);
    int i = 0;
    while (tx_busy !== 1'b0 && i < limit) begin
      tick();
      i++;
    end
    checkOutput(name, {31'd0, tx_busy}, 32'd0);
  endtask

  function automatic logic [7:0] qByte(input int i);
    return (i < rx_q.size()) ? rx_q[i] : 8'hxx;
  endfunction

  function automatic int qGap(input int i);
    return (i < start_q.size()) ? (start_q[i] - start_q[i-1]) : -1;
  endfunction

  task automatic clearQueues();
    rx_q.delete();
    start_q.delete();
  endtask

  initial begin : main
    vec_t       vecs[5];
    logic [7:0] wrap_bytes[10];
    int         lows;
    int         idx;
    int         n;

    vecs[0] = '{8'hA5, 10'b1101001010};
    vecs[1] = '{8'h00, 10'b1000000000};
    vecs[2] = '{8'hFF, 10'b1111111110};
    vecs[3] = '{8'h3C, 10'b1001111000};
    vecs[4] = '{8'h81, 10'b1100000010};

    wrap_bytes = '{8'h5A, 8'hC3, 8'h17, 8'hE8, 8'h42, 8'h99, 8'h0F, 8'hB6, 8'h71, 8'h2D};

    $display("[TB] reset");
    repeat (3) tick();
    checkOutput("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
    checkOutput("rst_tx_busy", {31'd0, tx_busy}, 32'd0);
    checkOutput("rst_fifo_full", {31'd0, fifo_full}, 32'd0);
    checkOutput("rst_overflow", {31'd0, overflow}, 32'd0);
    sys_rst = 1'b1;
    repeat (2) tick();

    $display("[TB] single-byte vector table");
    for (int v = 0; v < 5; v++) begin
      applyStimulus(vecs[v].data);
      checkOutput($sformatf("v%0d_prefall_tx", v), {31'd0, uart_tx}, 32'd1);
      checkOutput($sformatf("v%0d_prefall_busy", v), {31'd0, tx_busy}, 32'd1);
      tick();
      for (int k = 0; k < 100; k++) begin
        checkOutput($sformatf("v%0d_line_k%0d", v, k), {31'd0, uart_tx}, {31'd0, vecs[v].line[k/10]});
        checkOutput($sformatf("v%0d_busy_k%0d", v, k), {31'd0, tx_busy}, 32'd1);
        tick();
      end
      checkOutput($sformatf("v%0d_end_tx", v), {31'd0, uart_tx}, 32'd1);
      checkOutput($sformatf("v%0d_end_busy", v), {31'd0, tx_busy}, 32'd0);
      tick();
    end

    $display("[TB] burst of three");
    clearQueues();
    for (int i = 0; i < 3; i++) begin
      send_data = 8'(i + 1);
      send_en   = 1'b1;
      tick();
    end
    send_en = 1'b0;
    waitFrames(3, 400, "burst_frames");
    for (int i = 0; i < 3; i++) checkOutput($sformatf("burst_byte%0d", i), {24'd0, qByte(i)}, 32'(i + 1));
    for (int i = 1; i < 3; i++) checkOutput($sformatf("burst_gap%0d", i), qGap(i), 32'd100);
    waitIdle(50, "burst_idle");

    $display("[TB] overflow");
    clearQueues();
    for (int i = 0; i < 6; i++) begin
      send_data = 8'(8'h11 + i);
      send_en   = 1'b1;
      tick();
      if (i == 4) begin
        checkOutput("ovf_full_after5", {31'd0, fifo_full}, 32'd1);
        checkOutput("ovf_noovf_after5", {31'd0, overflow}, 32'd0);
      end
      if (i == 5) checkOutput("ovf_pulse", {31'd0, overflow}, 32'd1);
    end
    send_en = 1'b0;
    tick();
    checkOutput("ovf_pulse_end", {31'd0, overflow}, 32'd0);
    checkOutput("ovf_still_full", {31'd0, fifo_full}, 32'd1);
    waitFrames(5, 700, "ovf_frames");
    repeat (150) tick();
    checkOutput("ovf_frame_count", rx_q.size(), 32'd5);
    for (int i = 0; i < 5; i++) checkOutput($sformatf("ovf_byte%0d", i), {24'd0, qByte(i)}, 32'(8'h11 + i));
    for (int i = 1; i < 5; i++) checkOutput($sformatf("ovf_gap%0d", i), qGap(i), 32'd100);
    waitIdle(50, "ovf_idle");

    $display("[TB] full with simultaneous pop");
    clearQueues();
    for (int i = 0; i < 5; i++) begin
      send_data = 8'(8'h21 + i);
      send_en   = 1'b1;
      tick();
    end
    send_en = 1'b0;
    repeat (96) tick();
    checkOutput("fwp_full_before", {31'd0, fifo_full}, 32'd1);
    send_data = 8'hEE;
    send_en   = 1'b1;
    tick();
    send_en   = 1'b0;
    checkOutput("fwp_overflow", {31'd0, overflow}, 32'd1);
    checkOutput("fwp_not_full", {31'd0, fifo_full}, 32'd0);
    checkOutput("fwp_busy", {31'd0, tx_busy}, 32'd1);
    tick();
    checkOutput("fwp_overflow_end", {31'd0, overflow}, 32'd0);
    applyStimulus(8'h26);
    checkOutput("fwp_refill_full", {31'd0, fifo_full}, 32'd1);
    checkOutput("fwp_refill_noovf", {31'd0, overflow}, 32'd0);
    waitFrames(6, 800, "fwp_frames");
    repeat (150) tick();
    checkOutput("fwp_frame_count", rx_q.size(), 32'd6);
    for (int i = 0; i < 6; i++) checkOutput($sformatf("fwp_byte%0d", i), {24'd0, qByte(i)}, 32'(8'h21 + i));
    waitIdle(50, "fwp_idle");

    $display("[TB] reset mid-frame");
    clearQueues();
    send_data = 8'h00;
    send_en   = 1'b1;
    tick();
    send_data = 8'h55;
    tick();
    send_en   = 1'b0;
    repeat (43) tick();
    sys_rst = 1'b0;
    tick();
    checkOutput("mrst_uart_tx", {31'd0, uart_tx}, 32'd1);
    checkOutput("mrst_tx_busy", {31'd0, tx_busy}, 32'd0);
    checkOutput("mrst_fifo_full", {31'd0, fifo_full}, 32'd0);
    sys_rst = 1'b1;
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (uart_tx !== 1'b1) lows++;
    end
    checkOutput("mrst_line_low_cycles", lows, 32'd0);
    checkOutput("mrst_frames", rx_q.size(), 32'd0);
    checkOutput("mrst_busy_after", {31'd0, tx_busy}, 32'd0);

    $display("[TB] pointer wrap");
    clearQueues();
    idx = 0;
    while (idx < 10) begin
      n = (10 - idx < 3) ? (10 - idx) : 3;
      for (int j = 0; j < n; j++) begin
        send_data = wrap_bytes[idx + j];
        send_en   = 1'b1;
        tick();
      end
      send_en = 1'b0;
      idx += n;
      waitIdle(400, $sformatf("wrap_idle_%0d", idx));
    end
    repeat (5) tick();
    checkOutput("wrap_frame_count", rx_q.size(), 32'd10);
    for (int i = 0; i < 10; i++) checkOutput($sformatf("wrap_byte%0d", i), {24'd0, qByte(i)}, {24'd0, wrap_bytes[i]});

    checkOutput("framing_errors", frame_err, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
